// File: rtl/lsu_stage.sv
// lsu_stage: load/store unit behind the issue stage.
// Takes one memory uop per dispatch and forms the effective address base+imm.
// Runs a single access on the req/gnt/rvalid data port.
// Formats load data and returns it on the writeback bus as a one-cycle pulse.
// Optional feature: define LSU_MISALIGN_EXC_EN to trap misaligned H/W accesses
// with an exception pulse. The access is then never issued.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | ready for a new uop, no back-pressure
// REQ   | request on the bus, address/lanes held until granted
// WAIT  | load granted, waiting for rvalid to write back
// DRAIN | load killed after grant, swallow its rvalid silently
// EXC   | (LSU_MISALIGN_EXC_EN only) exception pulse cycle
module lsu_stage #(
    parameter int XLEN    = 32,
    parameter int DMEM_AW = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_valid,
    input  logic               i_is_store,
    input  logic [2:0]         i_funct3,
    input  logic [4:0]         i_rd,
    input  logic [XLEN-1:0]    i_imm,
    input  logic [XLEN-1:0]    i_addr_base,
    input  logic [XLEN-1:0]    i_store_data,
    input  logic               i_flush,
    output logic               o_stall,
    output logic               o_dmem_req,
    output logic               o_dmem_we,
    output logic [DMEM_AW-1:0] o_dmem_addr,
    output logic [3:0]         o_dmem_be,
    output logic [XLEN-1:0]    o_dmem_wdata,
    input  logic               i_dmem_gnt,
    input  logic               i_dmem_rvalid,
    input  logic [XLEN-1:0]    i_dmem_rdata,
`ifdef LSU_MISALIGN_EXC_EN
    output logic               o_exc_valid,
    output logic [3:0]         o_exc_cause,
    output logic [XLEN-1:0]    o_exc_addr,
`endif
    output logic               o_wb_valid,
    output logic [4:0]         o_wb_rd,
    output logic [XLEN-1:0]    o_wb_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
`ifdef LSU_MISALIGN_EXC_EN
        S_EXC,
`endif
        S_DRAIN
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] ea;
    logic            accept;
    logic            wb_fire;
    logic [3:0]      be_new;
    logic [XLEN-1:0] wdata_new;
    logic [XLEN-1:0] fmt;
    logic [2:0]      f3_q;
    logic [4:0]      rd_q;
    logic [1:0]      off_q;

    assign ea      = i_addr_base + i_imm;
    assign accept  = (state_q == S_IDLE) && i_valid && !i_flush;
    // A flush that lands together with rvalid kills the writeback; the data is already back.
    assign wb_fire = (state_q == S_WAIT) && i_dmem_rvalid && !i_flush;

`ifdef LSU_MISALIGN_EXC_EN
    logic misaligned;
    assign misaligned = ((i_funct3[1:0] == 2'b01) && ea[0]) ||
                        (i_funct3[1] && (ea[1:0] != 2'b00));
`endif

    // Store lane enables and replicated write data for the uop being accepted
    always_comb begin
        be_new    = 4'b1111;
        wdata_new = i_store_data;
        case (i_funct3[1:0])
            2'b00: begin
                be_new    = 4'b0001 << ea[1:0];
                wdata_new = {4{i_store_data[7:0]}};
            end
            2'b01: begin
                be_new    = 4'b0011 << {ea[1], 1'b0};
                wdata_new = {2{i_store_data[15:0]}};
            end
            default: ;
        endcase
        if (!i_is_store) be_new = 4'b1111;
    end

    // Load data alignment and sign/zero extension
    always_comb begin
        fmt = i_dmem_rdata;
        case (f3_q)
            3'b000: fmt = {{24{i_dmem_rdata[{off_q, 3'b111}]}}, i_dmem_rdata[{off_q, 3'b000} +: 8]};
            3'b100: fmt = {24'b0, i_dmem_rdata[{off_q, 3'b000} +: 8]};
            3'b001: fmt = {{16{i_dmem_rdata[{off_q[1], 4'b1111}]}}, i_dmem_rdata[{off_q[1], 4'b0000} +: 16]};
            3'b101: fmt = {16'b0, i_dmem_rdata[{off_q[1], 4'b0000} +: 16]};
            default: fmt = i_dmem_rdata;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state decode, request and back-pressure
    always_comb begin
        state_d    = state_q;
        o_stall    = (state_q != S_IDLE);
        o_dmem_req = (state_q == S_REQ);
        case (state_q)
            S_IDLE: begin
                if (accept) begin
`ifdef LSU_MISALIGN_EXC_EN
                    state_d = misaligned ? S_EXC : S_REQ;
`else
                    state_d = S_REQ;
`endif
                end
            end
            S_REQ: begin
                // Once granted the access completes on the bus; a flush only suppresses writeback.
                if (i_dmem_gnt)   state_d = o_dmem_we ? S_IDLE : (i_flush ? S_DRAIN : S_WAIT);
                else if (i_flush) state_d = S_IDLE;
            end
            S_WAIT: begin
                if (i_dmem_rvalid) state_d = S_IDLE;
                else if (i_flush)  state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (i_dmem_rvalid) state_d = S_IDLE;
            end
`ifdef LSU_MISALIGN_EXC_EN
            S_EXC:   state_d = S_IDLE;
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // Capture the uop and its bus image at accept; held stable through REQ
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_dmem_we    <= 1'b0;
            o_dmem_addr  <= '0;
            o_dmem_be    <= 4'b0000;
            o_dmem_wdata <= '0;
            f3_q         <= 3'b000;
            rd_q         <= 5'd0;
            off_q        <= 2'b00;
        end else if (accept) begin
            o_dmem_we    <= i_is_store;
            o_dmem_addr  <= {ea[DMEM_AW-1:2], 2'b00};
            o_dmem_be    <= be_new;
            o_dmem_wdata <= wdata_new;
            f3_q         <= i_funct3;
            rd_q         <= i_rd;
            off_q        <= ea[1:0];
        end
    end

    // Writeback pulse; x0 destinations still access memory but never write back
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_wb_valid <= 1'b0;
            o_wb_rd    <= 5'd0;
            o_wb_data  <= '0;
        end else begin
            o_wb_valid <= wb_fire && (rd_q != 5'd0);
            if (wb_fire) begin
                o_wb_rd   <= rd_q;
                o_wb_data <= fmt;
            end
        end
    end

`ifdef LSU_MISALIGN_EXC_EN
    // Misalignment exception pulse in the cycle after accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_exc_valid <= 1'b0;
            o_exc_cause <= 4'd0;
            o_exc_addr  <= '0;
        end else begin
            o_exc_valid <= accept && misaligned;
            if (accept && misaligned) begin
                o_exc_cause <= i_is_store ? 4'd6 : 4'd4;
                o_exc_addr  <= ea;
            end
        end
    end
`endif

endmodule
